// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO registers and busy-period stall
// Results are computed at issue, held pending, and committed when the busy counter expires.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op_D,
    input  logic [3:0]  mdu_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] mdu_out_E,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic          r_pend_we;

    logic          w_is_md, w_is_mult;
    logic [63:0]   w_prod_s, w_prod_u;
    logic          w_rs_neg, w_rt_neg;
    logic [31:0]   w_abs_rs, w_abs_rt, w_dvsr, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [31:0]   w_res_hi, w_res_lo;
    logic          w_res_we;

    assign w_is_md   = (mdu_op_E >= OP_MULT) && (mdu_op_E <= OP_DIVU);
    assign w_is_mult = (mdu_op_E == OP_MULT) || (mdu_op_E == OP_MULTU);
    assign start     = w_is_md && !r_busy;
    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_md  = (mdu_op_D >= OP_MULT) && (mdu_op_D <= OP_MTLO) && (start || r_busy);
    assign mdu_out_E = (mdu_op_E == OP_MFHI) ? r_hi :
                       (mdu_op_E == OP_MFLO) ? r_lo : 32'd0;

    assign w_prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
    assign w_prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    // One unsigned divider serves both div and divu; signed div works on magnitudes,
    // which also makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
    assign w_rs_neg = (mdu_op_E == OP_DIV) && rs_E[31];
    assign w_rt_neg = (mdu_op_E == OP_DIV) && rt_E[31];
    assign w_abs_rs = w_rs_neg ? -rs_E : rs_E;
    assign w_abs_rt = w_rt_neg ? -rt_E : rt_E;
    assign w_dvsr   = (rt_E == 32'd0) ? 32'd1 : w_abs_rt;
    assign w_q_mag  = w_abs_rs / w_dvsr;
    assign w_r_mag  = w_abs_rs % w_dvsr;
    assign w_quot   = (w_rs_neg ^ w_rt_neg) ? -w_q_mag : w_q_mag;
    assign w_rem    = w_rs_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
        w_res_we = (rt_E != 32'd0);
        if (mdu_op_E == OP_MULT) begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
            w_res_we = 1'b1;
        end else if (mdu_op_E == OP_MULTU) begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
            w_res_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                if (r_pend_we) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= w_res_we;
            r_cnt     <= w_is_mult ? CW'(MULT_LAT) : CW'(DIV_LAT);
            r_busy    <= 1'b1;
        end else if (mdu_op_E == OP_MTHI) begin
            r_hi <= rs_E;
        end else if (mdu_op_E == OP_MTLO) begin
            r_lo <= rs_E;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl against a behavioural HI/LO model
module tb_mdu_ctrl;
    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op_D, mdu_op_E;
    logic [31:0] rs_E, rt_E;
    logic        start, busy, stall_md;
    logic [31:0] mdu_out_E, hi, lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwe;
    int          m_left = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .mdu_op_D(mdu_op_D), .mdu_op_E(mdu_op_E),
        .rs_E(rs_E), .rt_E(rt_E), .start(start), .busy(busy), .stall_md(stall_md),
        .mdu_out_E(mdu_out_E), .hi(hi), .lo(lo)
    );

    function automatic bit m_start();
        return (mdu_op_E >= 1) && (mdu_op_E <= 4) && (m_left == 0);
    endfunction

    function automatic bit m_stall();
        return (mdu_op_D >= 1) && (mdu_op_D <= 8) && (m_start() || m_left > 0);
    endfunction

    function automatic logic [31:0] m_out();
        if (mdu_op_E == 4'd5) return m_hi;
        if (mdu_op_E == 4'd6) return m_lo;
        return 32'd0;
    endfunction

    task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        m_pwe = 1'b1;
        if (op == 4'd1 || op == 4'd2) begin
            p = (op == 4'd1) ? sa * sb : ua * ub;
            m_phi = p[63:32];
            m_plo = p[31:0];
        end else if (b == 32'd0) begin
            m_pwe = 1'b0;
        end else begin
            p = (op == 4'd3) ? sa / sb : ua / ub;
            m_plo = p[31:0];
            p = (op == 4'd3) ? sa % sb : ua % ub;
            m_phi = p[31:0];
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwe) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (mdu_op_E >= 1 && mdu_op_E <= 4) begin
            compute(mdu_op_E, rs_E, rt_E);
            m_left = (mdu_op_E <= 2) ? ML : DL;
        end else if (mdu_op_E == 4'd7) begin
            m_hi = rs_E;
        end else if (mdu_op_E == 4'd8) begin
            m_lo = rs_E;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] d, input logic [3:0] e,
                         input logic [31:0] a, input logic [31:0] b);
        reset = r; mdu_op_D = d; mdu_op_E = e; rs_E = a; rt_E = b;
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        drive(0, 0, op, a, b);
        cyc();
        drive(0, 0, 0, 0, 0);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            cyc();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        total++; if (start !== 1'b0 || stall_md !== 1'b0 || mdu_out_E !== 32'd0) begin
            bad++; $display("FAIL reset_comb: got start=%b stall=%b out=%h want 0 0 0", start, stall_md, mdu_out_E);
        end
        drive(1, 6, 1, 3, 4);
        total++; if (start !== 1'b1 || stall_md !== 1'b1) begin
            bad++; $display("FAIL reset_start_comb: got start=%b stall=%b want 1 1", start, stall_md);
        end
        drive(1, 0, 7, 5, 0);
        cyc();
        total++; if (hi !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_prio_mthi: got hi=%h busy=%b want 0 0", hi, busy);
        end
    endtask

    task automatic test_mult();
        int n;
        issue(1, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_lat: got %0d want 5", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL mult_res: got %h_%h want ffffffff_fffffffe", hi, lo);
        end
        issue(2, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL multu_lat: got %0d want 5", n); end
        total++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL multu_res: got %h_%h want 00000001_fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        issue(3, 32'hFFFF_FFF9, 32'd2, n);
        total++; if (n != 10) begin bad++; $display("FAIL div_lat: got %0d want 10", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", hi, lo);
        end
        issue(3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        total++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            bad++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_divzero();
        int n;
        drive(0, 0, 7, 32'h11, 0);
        cyc();
        drive(0, 0, 8, 32'h22, 0);
        cyc();
        issue(4, 32'h1234, 32'd0, n);
        total++; if (n != 10) begin bad++; $display("FAIL divzero_lat: got %0d want 10", n); end
        total++; if (hi !== 32'h11 || lo !== 32'h22) begin
            bad++; $display("FAIL divzero_keep: got %h_%h want 00000011_00000022", hi, lo);
        end
    endtask

    task automatic test_stall();
        drive(0, 6, 1, 3, 4);
        total++; if (start !== 1'b1 || stall_md !== 1'b1) begin
            bad++; $display("FAIL stall_start: got start=%b stall=%b want 1 1", start, stall_md);
        end
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(0, 6, 0, 0, 0);
            total++; if (busy !== 1'b1 || stall_md !== 1'b1) begin
                bad++; $display("FAIL stall_busy%0d: got busy=%b stall=%b want 1 1", i, busy, stall_md);
            end
            cyc();
        end
        drive(0, 6, 0, 0, 0);
        total++; if (busy !== 1'b0 || stall_md !== 1'b0) begin
            bad++; $display("FAIL stall_after: got busy=%b stall=%b want 0 0", busy, stall_md);
        end
        drive(0, 0, 6, 0, 0);
        total++; if (mdu_out_E !== 32'd12) begin bad++; $display("FAIL mflo_out: got %h want 0000000c", mdu_out_E); end
        drive(0, 0, 1, 5, 6);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 7, 7);
            total++; if (stall_md !== 1'b0 || start !== 1'b0) begin
                bad++; $display("FAIL nostall_busy%0d: got stall=%b start=%b want 0 0", i, stall_md, start);
            end
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        total++; if (busy !== 1'b0 || lo !== 32'd30 || hi !== 32'd0) begin
            bad++; $display("FAIL ignored_start: got busy=%b hi=%h lo=%h want 0 0 1e", busy, hi, lo);
        end
    endtask

    task automatic test_mthi();
        int n;
        drive(0, 0, 7, 32'hABCD, 0);
        cyc();
        drive(0, 0, 5, 0, 0);
        total++; if (hi !== 32'hABCD || mdu_out_E !== 32'hABCD) begin
            bad++; $display("FAIL mthi_mfhi: got hi=%h out=%h want abcd abcd", hi, mdu_out_E);
        end
        drive(0, 0, 1, 2, 3);
        cyc();
        drive(0, 0, 7, 32'h1234, 0);
        cyc();
        drive(0, 0, 5, 0, 0);
        total++; if (hi !== 32'hABCD || mdu_out_E !== 32'hABCD) begin
            bad++; $display("FAIL mthi_busy: got hi=%h out=%h want abcd abcd", hi, mdu_out_E);
        end
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            cyc();
        end
        total++; if (hi !== 32'd0 || lo !== 32'd6) begin
            bad++; $display("FAIL mthi_then_mult: got %h_%h want 00000000_00000006", hi, lo);
        end
    endtask

    task automatic test_reset_busy();
        drive(0, 0, 8, 32'h55, 0);
        cyc();
        drive(0, 0, 3, 32'd100, 32'd7);
        cyc();
        drive(0, 0, 0, 0, 0);
        repeat (3) cyc();
        drive(1, 0, 0, 0, 0);
        cyc();
        total++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_abort: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        drive(0, 0, 0, 0, 0);
        repeat (12) cyc();
        total++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_no_late_write: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8)),
                  pick(), pick());
            total++; if (start !== m_start()) begin bad++; $display("FAIL rnd_start@%0d: got %b want %b", i, start, m_start()); end
            total++; if (busy !== (m_left > 0)) begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, m_left > 0); end
            total++; if (stall_md !== m_stall()) begin bad++; $display("FAIL rnd_stall@%0d: got %b want %b", i, stall_md, m_stall()); end
            total++; if (mdu_out_E !== m_out()) begin bad++; $display("FAIL rnd_out@%0d: got %h want %h", i, mdu_out_E, m_out()); end
            total++; if (hi !== m_hi) begin bad++; $display("FAIL rnd_hi@%0d: got %h want %h", i, hi, m_hi); end
            total++; if (lo !== m_lo) begin bad++; $display("FAIL rnd_lo@%0d: got %h want %h", i, lo, m_lo); end
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1; mdu_op_D = 0; mdu_op_E = 0; rs_E = 0; rt_E = 0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_stall();
        test_mthi();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
